// File: rtl/tb_check_pkg.sv
// Shared types and constants for the stream checker: FSM state, LFSR taps, pattern modes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_e        checker FSM states
//   TAPS_*         Galois LFSR tap constants per supported width
//   PAT_*          expected-data source selection
//   lfsr_taps()    tap constant for a given width (8, 16, 32)
package tb_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;

  localparam int PAT_INC  = 0;
  localparam int PAT_LFSR = 1;

  // Unsupported widths fall back to the 32-bit taps; callers truncate.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return {24'h0, TAPS_8};
      16:      return {16'h0, TAPS_16};
      default: return TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/tb_pattern_gen.sv
// Expected-value sequence source: incrementing counter or right-shifting Galois LFSR.
// Latency: value updates on the edge after load/advance; load wins over advance.
// Backpressure: none; advances only when told to.
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, value returns to the seed
//   load     reload the seed
//   advance  step to the next value
//   value    current expected value
module tb_pattern_gen
  import tb_check_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          PATTERN = PAT_INC,
  parameter int unsigned SEED    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] value
);

  localparam logic [DATA_W-1:0] TAPS     = DATA_W'(lfsr_taps(DATA_W));
  localparam logic [DATA_W-1:0] SEED_RAW = DATA_W'(SEED);
  // An all-zero LFSR state would lock up, so a zero seed becomes 1 in LFSR mode.
  localparam logic [DATA_W-1:0] SEED_EFF =
      ((PATTERN == PAT_LFSR) && (SEED_RAW == '0)) ? DATA_W'(1) : SEED_RAW;

  logic [DATA_W-1:0] value_q;
  logic [DATA_W-1:0] value_d;
  logic [DATA_W-1:0] step;

  always_comb begin
    if (PATTERN == PAT_LFSR) begin
      step = value_q[0] ? ((value_q >> 1) ^ TAPS) : (value_q >> 1);
    end else begin
      step = value_q + DATA_W'(1);
    end
    value_d = value_q;
    if (load) begin
      value_d = SEED_EFF;
    end else if (advance) begin
      value_d = step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= SEED_EFF;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/tb_stream_checker.sv
// Self-checking stream sink: compares accepted beats to an expected pattern, tallies, detects stalls.
// Latency: counters/first_err_* update one cycle after a beat; done rises the cycle after the last beat.
// Backpressure: s_ready high throughout RUN; with TB_CHECK_BACKPRESSURE_EN it follows an LFSR bit.
//
// Optional feature macro: TB_CHECK_BACKPRESSURE_EN (pseudo-random s_ready during RUN).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, expect_len        begin a run of expect_len beats (ignored while busy)
//   s_valid, s_data, s_ready upstream valid/ready beat interface
//   busy, done, pass         RUN / DONE indication, run verdict (valid while done)
//   timeout                  run ended on a stall
//   match_cnt, mismatch_cnt  saturating beat tallies
//   first_err_idx/data/exp   index, received and expected data of the first mismatch
module tb_stream_checker
  import tb_check_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          CNT_W   = 16,
  parameter int          PATTERN = PAT_INC,
  parameter int unsigned SEED    = 1,
  parameter int          TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  expect_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp
);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  match_cnt_q;
  logic [CNT_W-1:0]  mismatch_cnt_q;
  logic [CNT_W-1:0]  first_err_idx_q;
  logic [DATA_W-1:0] first_err_data_q;
  logic [DATA_W-1:0] first_err_exp_q;
  logic [31:0]       stall_q;

  logic [CNT_W-1:0]  idx_d;
  logic [CNT_W-1:0]  match_cnt_d;
  logic [CNT_W-1:0]  mismatch_cnt_d;
  logic [31:0]       stall_d;

  logic [DATA_W-1:0] exp_val;
  logic              ready;
  logic              start_ok;
  logic              hs;
  logic              beat_ok;
  logic              last_beat;
  logic              stall_cyc;
  logic              stall_hit;

  assign start_ok  = start && (state_q != RUN);
  assign hs        = s_valid && ready;
  assign beat_ok   = (s_data == exp_val);
  assign last_beat = (idx_q == (len_q - CNT_W'(1)));
  // A cycle where the checker is not offering ready is never blamed on upstream.
  assign stall_cyc = ready && !s_valid;

  // Saturating increments; counters stick at all-ones rather than wrapping.
  assign idx_d          = (idx_q == '1)          ? idx_q          : idx_q + CNT_W'(1);
  assign match_cnt_d    = (match_cnt_q == '1)    ? match_cnt_q    : match_cnt_q + CNT_W'(1);
  assign mismatch_cnt_d = (mismatch_cnt_q == '1) ? mismatch_cnt_q : mismatch_cnt_q + CNT_W'(1);
  assign stall_d        = (stall_q == '1)        ? stall_q        : stall_q + 32'd1;
  assign stall_hit      = (TIMEOUT != 0) && (stall_d == 32'(TIMEOUT));

  tb_pattern_gen #(
    .DATA_W  (DATA_W),
    .PATTERN (PATTERN),
    .SEED    (SEED)
  ) u_exp (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .advance (hs),
    .value   (exp_val)
  );

`ifdef TB_CHECK_BACKPRESSURE_EN
  logic [15:0] bp_val;

  // Free-running while in RUN, restarted from its seed on every accepted start.
  tb_pattern_gen #(
    .DATA_W  (16),
    .PATTERN (PAT_LFSR),
    .SEED    (32'h0000_ACE1)
  ) u_bp (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .advance (busy_q),
    .value   (bp_val)
  );

  assign ready = busy_q && bp_val[0];
`else
  assign ready = busy_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      len_q            <= '0;
      idx_q            <= '0;
      match_cnt_q      <= '0;
      mismatch_cnt_q   <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      first_err_exp_q  <= '0;
      stall_q          <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            len_q            <= expect_len;
            idx_q            <= '0;
            match_cnt_q      <= '0;
            mismatch_cnt_q   <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            stall_q          <= '0;
            timeout_q        <= 1'b0;
            if (expect_len == '0) begin
              // Nothing to receive: the run is trivially clean.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end

        RUN: begin
          if (hs) begin
            stall_q <= '0;
            idx_q   <= idx_d;
            if (beat_ok) begin
              match_cnt_q <= match_cnt_d;
            end else begin
              mismatch_cnt_q <= mismatch_cnt_d;
              // The tally saturates and never returns to zero, so zero means "no error yet".
              if (mismatch_cnt_q == '0) begin
                first_err_idx_q  <= idx_q;
                first_err_data_q <= s_data;
                first_err_exp_q  <= exp_val;
              end
            end
            if (last_beat) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mismatch_cnt_q == '0) && beat_ok;
            end
          end else if (stall_cyc) begin
            stall_q <= stall_d;
            if (stall_hit) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
              pass_q    <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready        = ready;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign match_cnt      = match_cnt_q;
  assign mismatch_cnt   = mismatch_cnt_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign first_err_exp  = first_err_exp_q;

endmodule
